vector_scalar_mult: RTL and testbench
=====================================

Name: vector_scalar_mult

Overview:
- Multiplies a signed fixed-point vector by one signed fixed-point scalar, e.g. gradient × learning rate.
- Produces the weight-update vector consumed on the b input of the downstream vector_add stage in the backpropagation path.
- Processes TILING elements per cycle to share multipliers.
- Uses valid/ready handshakes on both inputs and the output, matching the adjacent stages.

Parameters:
- VECTOR_LEN, 5: number of vector elements.
- A_CELL_WIDTH, 8: signed width of each vector element.
- B_CELL_WIDTH, 8: signed width of the scalar.
- RESULT_CELL_WIDTH, 8: signed width of each result element.
- FRACTION_WIDTH, 4: fractional bits of the scalar; the product is shifted right by this amount.
- TILING, 2: multipliers instantiated, i.e. elements processed per cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- a  in  VECTOR_LEN*A_CELL_WIDTH  vector; element i at [i*A_CELL_WIDTH +: A_CELL_WIDTH].
- a_valid  in  1  a is valid.
- a_ready  out  1  block can accept a.
- b  in  B_CELL_WIDTH  scalar.
- b_valid  in  1  b is valid.
- b_ready  out  1  block can accept b.
- result  out  VECTOR_LEN*RESULT_CELL_WIDTH  product vector; element i at [i*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH].
- result_valid  out  1  result is complete and stable.
- result_ready  in  1  consumer accepts result.
- error  out  1  at least one element of the current result saturated.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; a_got=0, b_got=0, tile counter=0.
  - result=0, result_valid=0, error=0.
  - a_ready=1 and b_ready=1 once rst deasserts.
- Reset asserted mid-operation aborts: partial results are discarded and all outputs take reset values.
- States:
  - IDLE:
    - a_ready = !a_got; b_ready = !b_got.
    - a_valid&&a_ready latches a and sets a_got. b_valid&&b_ready latches b and sets b_got. Both may happen in the same cycle.
    - When a_got&&b_got → CALC. The check uses registered flags, so IDLE lasts at least one cycle after the last capture.
    - valid is ignored while the matching flag is set; the latched operand does not change.
  - CALC:
    - a_ready=b_ready=0.
    - Each cycle computes elements tile*TILING .. tile*TILING+TILING-1; indices ≥ VECTOR_LEN are skipped.
    - Counter runs 0..NUM_TILES-1, where NUM_TILES = ceil(VECTOR_LEN/TILING). After the last tile → DONE.
  - DONE:
    - result_valid=1; result and error held stable.
    - On result_ready=1: clear a_got, b_got, counter and error → IDLE. result keeps its last value.
    - result_ready=0 holds DONE indefinitely.
- Latency: NUM_TILES cycles in CALC. result_valid rises NUM_TILES+1 cycles after the capture edge that completes both operands (3+1 with defaults).
- Throughput: new operands are accepted starting the cycle after the result handshake.
- Arithmetic, per element:
  - p = signed(a_i) * signed(b), full A_CELL_WIDTH+B_CELL_WIDTH bits.
  - s = p >>> FRACTION_WIDTH (arithmetic shift, floor).
  - If s > 2^(RESULT_CELL_WIDTH-1)-1, clamp to max; if s < -2^(RESULT_CELL_WIDTH-1), clamp to min. Any clamp sets error (sticky until the result handshake).
- No internal FIFO; back-pressure is handled purely through the ready signals.

Optional Feature:
- Macro VECTOR_SCALAR_MULT_ROUND_EN.
- Defined: add 2^(FRACTION_WIDTH-1) to p before the shift (round half up), then saturate.
- Undefined: truncation (floor). Port list and timing are identical either way.

Decomposition:
- Shared package: the saturate function/constants (SAT_MAX, SAT_MIN from RESULT_CELL_WIDTH), NUM_TILES computation (ceil-div function), and the state encoding constants IDLE/CALC/DONE.
- One sub-module: mult_sat_cell. Combinational signed multiply → shift/round → saturate, with an overflow flag. Instantiated TILING times in a generate loop; a tile-indexed mux feeds operands to it and a demux writes results into the result register.

Test Plan:
- Identity (V=5, T=2, W=8, F=4):
  - a={-50,40,30,20,-10}, b=16 (1.0), both valid the same cycle.
  - Expect result={-50,40,30,20,-10}, error=0, result_valid 4 cycles after capture.
- Scale 0.5, staggered arrival:
  - a valid, then b=8 valid 5 cycles later.
  - Expect a_ready=0 after a is captured, result={-25,20,15,10,-5}, error=0.
- Saturation:
  - b=64 (4.0) with the same a.
  - Expect result={-128,127,120,80,-40}, error=1.
  - error clears after the result_ready handshake.
- Back-pressure:
  - result_ready=0 for 10 cycles, with new a/b valid asserted during DONE.
  - Expect result_valid held and result stable; a_ready=b_ready=0.
  - After the handshake the new operands are captured the next cycle.
- Rounding: a_1=20, b=3.
  - Macro off: element=3.
  - VECTOR_SCALAR_MULT_ROUND_EN on: element=4.
- Reset mid-CALC:
  - Drive rst=0 during the second tile.
  - Expect immediate result=0, result_valid=0, error=0, state IDLE.
  - A subsequent identity run passes.

Source files
------------

// File: rtl/vector_scalar_mult_pkg.sv
// Shared types and helpers for vector_scalar_mult: FSM encoding, tile count and saturation limits.
package vector_scalar_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/vector_scalar_mult_mult_sat_cell.sv
// One combinational lane: signed multiply, fixed-point shift (optionally rounded), saturate.
// Rounding is selected by the VECTOR_SCALAR_MULT_ROUND_EN macro; floor truncation otherwise.
module mult_sat_cell
  import vector_scalar_mult_pkg::*;
#(
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION_WIDTH    = 4
) (
  input  logic [A_CELL_WIDTH-1:0]      a,
  input  logic [B_CELL_WIDTH-1:0]      b,
  output logic [RESULT_CELL_WIDTH-1:0] result,
  output logic                         overflow
);

  localparam int PW = A_CELL_WIDTH + B_CELL_WIDTH;

  logic signed [PW-1:0] p;
  logic signed [PW:0]   p_adj;
  logic signed [PW:0]   s;
  longint               s_wide;

  assign p = $signed(a) * $signed(b);

  // One guard bit keeps the rounding add from wrapping.
`ifdef VECTOR_SCALAR_MULT_ROUND_EN
  assign p_adj = {p[PW-1], p} + ((PW+1)'(1) << (FRACTION_WIDTH - 1));
`else
  assign p_adj = {p[PW-1], p};
`endif

  assign s      = p_adj >>> FRACTION_WIDTH;
  assign s_wide = longint'(s);

  always_comb begin
    result   = s[RESULT_CELL_WIDTH-1:0];
    overflow = 1'b0;
    if (s_wide > sat_max(RESULT_CELL_WIDTH)) begin
      result   = RESULT_CELL_WIDTH'(sat_max(RESULT_CELL_WIDTH));
      overflow = 1'b1;
    end else if (s_wide < sat_min(RESULT_CELL_WIDTH)) begin
      result   = RESULT_CELL_WIDTH'(sat_min(RESULT_CELL_WIDTH));
      overflow = 1'b1;
    end
  end

endmodule

// File: rtl/vector_scalar_mult.sv
// Vector x scalar fixed-point multiplier, TILING lanes per cycle, with saturation flag.
// Optional rounding via VECTOR_SCALAR_MULT_ROUND_EN (inside mult_sat_cell).
// Handshake: a word transfers on a rising edge where valid and ready are both 1; valid
// may be raised at any time, ready depends only on registered state, and result is
// held stable while result_valid is 1 until result_ready is seen.
module vector_scalar_mult
  import vector_scalar_mult_pkg::*;
#(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION_WIDTH    = 4,
  parameter int TILING            = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a,
  input  logic                                    a_valid,
  output logic                                    a_ready,
  input  logic [B_CELL_WIDTH-1:0]                 b,
  input  logic                                    b_valid,
  output logic                                    b_ready,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                    result_valid,
  input  logic                                    result_ready,
  output logic                                    error,
  output state_t                                  state
);

  localparam int NUM_TILES = ceil_div(VECTOR_LEN, TILING);
  localparam int SLOTS     = NUM_TILES * TILING;
  localparam int TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int SW        = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

  state_t                               state_q, state_d;
  logic                                 a_got, b_got;
  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]   a_q;
  logic [B_CELL_WIDTH-1:0]              b_q;
  logic [TW-1:0]                        tile_q;
  logic                                 err_q;
  logic [RESULT_CELL_WIDTH-1:0]         res_q    [VECTOR_LEN];
  logic [A_CELL_WIDTH-1:0]              a_slot   [SLOTS];
  logic [SW-1:0]                        lane_idx [TILING];
  logic                                 lane_ok  [TILING];
  logic [A_CELL_WIDTH-1:0]              lane_a   [TILING];
  logic [RESULT_CELL_WIDTH-1:0]         lane_res [TILING];
  logic                                 lane_ovf [TILING];

  // Pad the operand vector to a whole number of tiles so the lane mux never reads past it.
  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    if (s < VECTOR_LEN) begin : g_real
      assign a_slot[s] = a_q[s*A_CELL_WIDTH +: A_CELL_WIDTH];
    end else begin : g_pad
      assign a_slot[s] = '0;
    end
  end

  for (genvar j = 0; j < TILING; j++) begin : g_lane
    assign lane_idx[j] = SW'(int'(tile_q) * TILING + j);
    assign lane_ok[j]  = (int'(lane_idx[j]) < VECTOR_LEN);
    assign lane_a[j]   = a_slot[lane_idx[j]];

    mult_sat_cell #(
      .A_CELL_WIDTH     (A_CELL_WIDTH),
      .B_CELL_WIDTH     (B_CELL_WIDTH),
      .RESULT_CELL_WIDTH(RESULT_CELL_WIDTH),
      .FRACTION_WIDTH   (FRACTION_WIDTH)
    ) u_cell (
      .a       (lane_a[j]),
      .b       (b_q),
      .result  (lane_res[j]),
      .overflow(lane_ovf[j])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (a_got && b_got) state_d = CALC;
      CALC:    if (tile_q == LAST_TILE) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_got   <= 1'b0;
      b_got   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tile_q  <= '0;
      err_q   <= 1'b0;
      for (int e = 0; e < VECTOR_LEN; e++) res_q[e] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (a_valid && !a_got) begin
            a_q   <= a;
            a_got <= 1'b1;
          end
          if (b_valid && !b_got) begin
            b_q   <= b;
            b_got <= 1'b1;
          end
        end
        CALC: begin
          for (int j = 0; j < TILING; j++) begin
            if (lane_ok[j]) begin
              res_q[lane_idx[j]] <= lane_res[j];
              if (lane_ovf[j]) err_q <= 1'b1;
            end
          end
          if (tile_q != LAST_TILE) tile_q <= tile_q + 1'b1;
        end
        DONE: begin
          if (result_ready) begin
            a_got  <= 1'b0;
            b_got  <= 1'b0;
            tile_q <= '0;
            err_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar e = 0; e < VECTOR_LEN; e++) begin : g_pack
    assign result[e*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] = res_q[e];
  end

  assign a_ready      = (state_q == IDLE) && !a_got;
  assign b_ready      = (state_q == IDLE) && !b_got;
  assign result_valid = (state_q == DONE);
  assign error        = err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_vector_scalar_mult.sv
// Directed bench for vector_scalar_mult (default parameters) with a behavioural model and scoreboard.
module tb_vector_scalar_mult;
  import vector_scalar_mult_pkg::*;

  localparam int W = 41;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [39:0] a = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [7:0]  b = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [39:0] result;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic        error;
  state_t      state;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  vector_scalar_mult dut (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .b(b), .b_valid(b_valid), .b_ready(b_ready), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .error(error),
    .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] mk(input int e0, input int e1, input int e2, input int e3, input int e4);
    int e[5];
    logic [39:0] v;
    e = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < 5; i++) v[i*8 +: 8] = e[i][7:0];
    return v;
  endfunction

  // element value = floor((a*b [+ half]) / 16), clamped to [-128, 127]
  function automatic logic [W-1:0] model(input logic [39:0] av, input logic [7:0] bv);
    logic [39:0] r;
    logic        err;
    int          p;
    int          s;
    err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p = int'($signed(av[i*8 +: 8])) * int'($signed(bv));
`ifdef VECTOR_SCALAR_MULT_ROUND_EN
      p = p + 8;
`endif
      s = p >>> 4;
      if (s > 127) begin s = 127; err = 1'b1; end
      else if (s < -128) begin s = -128; err = 1'b1; end
      r[i*8 +: 8] = s[7:0];
    end
    return {err, r};
  endfunction

  // scoreboard: every cycle the result is offered it must match the head of the queue
  always @(negedge clk) begin
    if (rst && result_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got %h, expected no result", {error, result});
      end else begin
        chk("scoreboard", 64'({error, result}), 64'(exp_q[0]));
        if (result_ready) void'(exp_q.pop_front());
      end
    end
  end

  // driver: presents a, and b after gap cycles (gap 0 = same cycle); returns #1 after last capture
  task automatic drive_ops(input logic [39:0] av, input logic [7:0] bv, input int gap);
    bit ad = 1'b0;
    bit bd = 1'b0;
    bit ta, tb;
    int cyc = 0;
    a = av;
    a_valid = 1'b1;
    if (gap == 0) begin b = bv; b_valid = 1'b1; end
    while (!(ad && bd)) begin
      if (cyc > 60) begin
        vectors++;
        miscompares++;
        $display("FAIL operand_handshake_timeout: got no capture, expected capture within 60 cycles");
        break;
      end
      @(negedge clk);
      ta = a_valid && a_ready && !ad;
      tb = b_valid && b_ready;
      if (ad && !bd) chk("a_ready_hold", 64'(a_ready), 64'(0));
      @(posedge clk); #1;
      cyc++;
      // after capture, keep a_valid high with junk: it must be ignored
      if (ta) begin ad = 1'b1; if (gap > 0) a = ~av; else a_valid = 1'b0; end
      if (tb) begin bd = 1'b1; b_valid = 1'b0; end
      if (!bd && !b_valid && cyc >= gap) begin b = bv; b_valid = 1'b1; end
    end
    a_valid = 1'b0;
  endtask

  task automatic wait_result(output int k);
    k = 0;
    while (1) begin
      @(negedge clk);
      if (result_valid) return;
      if (k >= 50) begin
        vectors++;
        miscompares++;
        $display("FAIL result_timeout: got no result_valid, expected within 50 cycles");
        return;
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic finish_hs();
    @(posedge clk); #1;
    chk("idle_after_hs", 64'(state), 64'(IDLE));
    chk("error_after_hs", 64'(error), 64'(0));
  endtask

  task automatic run(input logic [39:0] av, input logic [7:0] bv, input int gap);
    int k;
    exp_q.push_back(model(av, bv));
    drive_ops(av, bv, gap);
    wait_result(k);
    finish_hs();
  endtask

  initial begin
    int k;
    logic [39:0] v_id;
    v_id = mk(-50, 40, 30, 20, -10);

    // reset state
    #12;
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_valid", 64'(result_valid), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_state", 64'(state), 64'(IDLE));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_a_ready", 64'(a_ready), 64'(1));
    chk("rst_b_ready", 64'(b_ready), 64'(1));

    // identity, same-cycle arrival, latency 4
    exp_q.push_back(model(v_id, 8'd16));
    drive_ops(v_id, 8'd16, 0);
    wait_result(k);
    chk("ident_latency", 64'(k), 64'(4));
    chk("ident_lit", 64'({error, result}), 64'({1'b0, mk(-50, 40, 30, 20, -10)}));
    finish_hs();

    // scale 0.5, b arrives 5 cycles after a
    exp_q.push_back(model(v_id, 8'd8));
    drive_ops(v_id, 8'd8, 5);
    wait_result(k);
    chk("half_lit", 64'({error, result}), 64'({1'b0, mk(-25, 20, 15, 10, -5)}));
    finish_hs();

    // saturation, error clears after handshake
    exp_q.push_back(model(v_id, 8'd64));
    drive_ops(v_id, 8'd64, 0);
    wait_result(k);
    chk("sat_lit", 64'({error, result}), 64'({1'b1, mk(-128, 127, 120, 80, -40)}));
    finish_hs();

    // floor of negatives and extreme operands
    run(mk(-5, 7, -1, 100, -128), 8'd8, 0);
    run(mk(-128, 127, -128, 1, -1), 8'h80, 2);

    // rounding lane
    exp_q.push_back(model(mk(0, 20, -20, 7, 1), 8'd3));
    drive_ops(mk(0, 20, -20, 7, 1), 8'd3, 0);
    wait_result(k);
`ifdef VECTOR_SCALAR_MULT_ROUND_EN
    chk("round_elem1", 64'(result[15:8]), 64'(4));
`else
    chk("round_elem1", 64'(result[15:8]), 64'(3));
`endif
    finish_hs();

    // back-pressure with new operands waiting during DONE
    result_ready = 1'b0;
    exp_q.push_back(model(v_id, 8'd32));
    drive_ops(v_id, 8'd32, 0);
    wait_result(k);
    exp_q.push_back(model(mk(1, 2, 3, 4, 5), 8'd48));
    a = mk(1, 2, 3, 4, 5); a_valid = 1'b1;
    b = 8'd48; b_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_a_ready", 64'(a_ready), 64'(0));
      chk("bp_b_ready", 64'(b_ready), 64'(0));
      chk("bp_valid", 64'(result_valid), 64'(1));
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_accept_a", 64'(a_ready), 64'(1));
    chk("bp_accept_b", 64'(b_ready), 64'(1));
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("bp_captured", 64'({a_ready, b_ready}), 64'(0));
    wait_result(k);
    finish_hs();

    // reset during the second tile
    drive_ops(v_id, 8'd16, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_partial", 64'(result[15:0]), 64'(mk(-50, 40, 0, 0, 0)));
    rst = 1'b0;
    #1;
    chk("mid_rst_result", 64'(result), 64'(0));
    chk("mid_rst_valid", 64'(result_valid), 64'(0));
    chk("mid_rst_error", 64'(error), 64'(0));
    chk("mid_rst_state", 64'(state), 64'(IDLE));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(v_id, 8'd16));
    drive_ops(v_id, 8'd16, 0);
    wait_result(k);
    chk("post_rst_latency", 64'(k), 64'(4));
    chk("post_rst_lit", 64'({error, result}), 64'({1'b0, v_id}));
    finish_hs();

    repeat (2) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
